// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM block family: default counter width
// and the PWM decoder measurement state encoding.
package led_pkg;

    localparam int unsigned LED_CNT_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } meas_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus delay flop for an asynchronous waveform;
// presents the synchronized level and single-cycle rise/fall indications.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_s1;
    logic r_s2;
    logic r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_d  <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    assign o_level  = r_s2;
    assign o_rise_c = r_s2 & ~r_d;
    assign o_fall_c = ~r_s2 & r_d;

endmodule

// File: rtl/led_pwm_decoder.sv
// Measures high time and rise-to-rise period of one PWM waveform in clock
// cycles, strobing each completed period and flagging stuck lines.
module led_pwm_decoder
    import led_pkg::*;
#(
    parameter int unsigned N = LED_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         pwm_in,
    output logic [N-1:0] high_time,
    output logic [N-1:0] period,
    output logic         meas_valid,
    output logic         stuck_high,
    output logic         stuck_low
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic        w_level;
    logic        w_rise;
    logic        w_fall;
    logic        w_timeout;
    logic [N-1:0] w_pcnt_inc;
    logic [N-1:0] w_hcnt_inc;

    meas_state_t  r_state;
    logic [N-1:0] r_hcnt;
    logic [N-1:0] r_pcnt;

    pwm_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_async  (pwm_in),
        .o_level  (w_level),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // Counters saturate; a rise coinciding with a full period still reports.
    assign w_timeout  = (r_pcnt == CNT_MAX) & ~w_rise;
    assign w_pcnt_inc = (r_pcnt == CNT_MAX) ? r_pcnt : r_pcnt + N'(1);
    assign w_hcnt_inc = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + N'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hcnt     <= '0;
            r_pcnt     <= '0;
            high_time  <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                r_state    <= ST_IDLE;
                r_hcnt     <= '0;
                r_pcnt     <= '0;
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_hcnt  <= '0;
                        r_pcnt  <= '0;
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_hcnt  <= N'(1);
                            r_pcnt  <= N'(1);
                            r_state <= ST_HIGH;
                        end else if (w_timeout) begin
                            stuck_high <= w_level;
                            stuck_low  <= ~w_level;
                            r_hcnt     <= '0;
                            r_pcnt     <= '0;
                        end else begin
                            r_pcnt <= w_pcnt_inc;
                        end
                    end
                    ST_HIGH: begin
                        if (w_timeout) begin
                            stuck_high <= w_level;
                            stuck_low  <= ~w_level;
                            r_hcnt     <= '0;
                            r_pcnt     <= '0;
                            r_state    <= ST_ARM;
                        end else begin
                            r_pcnt <= w_pcnt_inc;
                            if (w_level) r_hcnt <= w_hcnt_inc;
                            if (w_fall)  r_state <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            high_time  <= r_hcnt;
                            period     <= r_pcnt;
                            meas_valid <= 1'b1;
                            stuck_high <= 1'b0;
                            stuck_low  <= 1'b0;
                            r_hcnt     <= N'(1);
                            r_pcnt     <= N'(1);
                            r_state    <= ST_HIGH;
                        end else if (w_timeout) begin
                            stuck_high <= w_level;
                            stuck_low  <= ~w_level;
                            r_hcnt     <= '0;
                            r_pcnt     <= '0;
                            r_state    <= ST_ARM;
                        end else begin
                            r_pcnt <= w_pcnt_inc;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
